// File: rtl/sid_write_sequencer.sv
`default_nettype none
// ============================================================================
// sid_write_sequencer : timed SID register-write sequencer with command FIFO.
// Optional macro SID_SEQ_READBACK_EN: addr 0x19..0x1C become reads (rd_valid).
// Rev 1.0
// ============================================================================
module sid_write_sequencer #(
  parameter int DUAL       = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DELAY_W    = 16,
  localparam int CS_W      = (DUAL != 0) ? 2 : 1,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_1m,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DELAY_W-1:0] cmd_delay,
  input  logic               cmd_sel,
  input  logic [4:0]         cmd_addr,
  input  logic [7:0]         cmd_data,
  input  logic               flush,
  input  logic               pause,
  output logic [CS_W-1:0]    sid_cs,
  output logic               sid_we,
  output logic [4:0]         sid_addr,
  output logic [7:0]         sid_data,
  input  logic [7:0]         sid_rdata,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               busy
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DELAY_W + 1 + 5 + 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [LVL_W-1:0]   r_level;
  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [DELAY_W-1:0] r_cnt;
  logic               r_sel;
  logic [4:0]         r_addr;
  logic [7:0]         r_data;
  logic [CS_W-1:0]    r_cs;
  logic               r_we;
  logic [4:0]         r_sid_addr;
  logic [7:0]         r_sid_data;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_tick;
  logic               w_pop;
  logic               w_fire;
  logic               w_dec;
  logic               w_is_read;
  logic [CS_W-1:0]    w_cs_sel;

  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_tick    = ce_1m && !pause;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_delay, cmd_sel, cmd_addr, cmd_data};
    end
  end

  // Flush wins over everything; push is already blocked by cmd_ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty && !flush) w_next_state = S_WAIT;
      S_WAIT: begin
        if (flush)                        w_next_state = S_IDLE;
        else if (w_tick && r_cnt == '0)   w_next_state = S_ISSUE;
      end
      S_ISSUE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop  = 1'b0;
    w_fire = 1'b0;
    w_dec  = 1'b0;
    if (r_state == S_IDLE) begin
      w_pop = !w_empty && !flush;
    end
    if (r_state == S_WAIT && !flush && w_tick) begin
      w_fire = (r_cnt == '0);
      w_dec  = (r_cnt != '0);
    end
  end

  generate
    if (DUAL != 0) begin : g_cs_dual
      assign w_cs_sel = r_sel ? 2'b10 : 2'b01;
    end else begin : g_cs_single
      assign w_cs_sel = 1'b1;
    end
  endgenerate

  // Strobe registers clear every clk so a fire yields exactly one ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_sel      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cs       <= '0;
      r_we       <= 1'b0;
      r_sid_addr <= '0;
      r_sid_data <= '0;
    end else begin
      r_cs <= '0;
      r_we <= 1'b0;
      if (w_pop) begin
        {r_cnt, r_sel, r_addr, r_data} <= r_mem[r_rptr];
      end else if (w_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire) begin
        r_cs       <= w_cs_sel;
        r_we       <= !w_is_read;
        r_sid_addr <= r_addr;
        r_sid_data <= r_data;
      end
    end
  end

`ifdef SID_SEQ_READBACK_EN
  logic       r_rd_pend;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;

  assign w_is_read = (r_addr >= 5'h19) && (r_addr <= 5'h1C);

  // r_rd_pend is high exactly during the ISSUE clk of a read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend  <= w_fire && w_is_read;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= sid_rdata;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
`else
  logic w_unused_rdata;

  assign w_is_read      = 1'b0;
  assign w_unused_rdata = ^sid_rdata;
  assign rd_valid       = 1'b0;
  assign rd_data        = 8'h00;
`endif

  assign sid_cs     = r_cs;
  assign sid_we     = r_we;
  assign sid_addr   = r_sid_addr;
  assign sid_data   = r_sid_data;
  assign fifo_level = r_level;
  assign busy       = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sid_write_sequencer.sv
`default_nettype none
// ============================================================================
// tb_sid_write_sequencer : directed + randomized bench with a transaction-level
// scoreboard timing each strobe from ce_1m tick history.
// Rev 1.0
// ============================================================================
module tb_sid_write_sequencer;

  localparam int MAXC = 40000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_1m;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_delay;
  logic        cmd_sel;
  logic [4:0]  cmd_addr;
  logic [7:0]  cmd_data;
  logic        flush;
  logic        pause;
  logic [1:0]  sid_cs;
  logic        sid_we;
  logic [4:0]  sid_addr;
  logic [7:0]  sid_data;
  logic [7:0]  sid_rdata;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [4:0]  fifo_level;
  logic        busy;

  sid_write_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_delay(cmd_delay),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .flush(flush), .pause(pause),
    .sid_cs(sid_cs), .sid_we(sid_we), .sid_addr(sid_addr), .sid_data(sid_data),
    .sid_rdata(sid_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_read(input logic [4:0] a);
`ifdef SID_SEQ_READBACK_EN
    return (a >= 5'h19) && (a <= 5'h1C);
`else
    return 1'b0;
`endif
  endfunction

  // Environment drivers: ce_1m period, pause and read data sources
  int         ce_per      = 32;
  int         ce_cnt      = 0;
  bit         pause_rand  = 0;
  bit         pause_force = 0;
  bit         rdata_rand  = 0;
  logic [7:0] rdata_fix   = 8'h00;

  initial begin
    ce_1m = 1'b0;
    pause = 1'b0;
    sid_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (ce_cnt >= ce_per - 1) begin ce_cnt = 0; ce_1m = 1'b1; end
      else begin ce_cnt++; ce_1m = 1'b0; end
      pause     = pause_rand ? ($urandom_range(0, 3) == 0) : pause_force;
      sid_rdata = rdata_rand ? 8'($urandom) : rdata_fix;
    end
  end

  // Scoreboard: expected commands in acceptance order with their push cycle
  typedef struct {
    int         d;
    bit         sel;
    logic [4:0] a;
    logic [7:0] dt;
    int         pc;
  } cmd_t;

  cmd_t       q[$];
  bit         tick_hist [MAXC];
  int         cyc = 0;
  int         free_c = 0;
  int         strobes = 0;
  int         accepted = 0;
  bit         rd_pend = 0;
  logic [7:0] rd_exp;
  cmd_t       mc;
  int         pop_c;
  int         exp_s;
  int         n_t;

  // A command starts counting after its pop, which happens one clk after it
  // is both present and the sequencer is free; it fires on the (d+1)-th
  // unpaused tick after that and strobes in the following clk.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      free_c  = cyc + 1;
      rd_pend = 0;
    end else begin
      if (cyc < MAXC) tick_hist[cyc] = ce_1m && !pause;
      if (rd_pend) begin
        check("rd_valid_pulse", {31'd0, rd_valid}, 32'd1);
        check("rd_data_value", {24'd0, rd_data}, {24'd0, rd_exp});
        rd_pend = 0;
      end
      if (sid_cs != 2'b00 || sid_we) begin
        strobes++;
        if (q.size() == 0) begin
          check("unexpected_strobe_cs", {30'd0, sid_cs}, 32'd0);
        end else begin
          mc    = q.pop_front();
          pop_c = (mc.pc + 1 > free_c) ? mc.pc + 1 : free_c;
          exp_s = -1;
          n_t   = 0;
          for (int k = pop_c + 1; k < cyc && k < MAXC; k++) begin
            if (tick_hist[k] && exp_s < 0) begin
              n_t++;
              if (n_t == mc.d + 1) exp_s = k + 1;
            end
          end
          check("strobe_cycle", cyc, exp_s);
          check("strobe_cs", {30'd0, sid_cs}, mc.sel ? 32'd2 : 32'd1);
          check("strobe_we", {31'd0, sid_we}, is_read(mc.a) ? 32'd0 : 32'd1);
          check("strobe_addr", {27'd0, sid_addr}, {27'd0, mc.a});
          check("strobe_data", {24'd0, sid_data}, {24'd0, mc.dt});
          if (is_read(mc.a)) begin
            rd_pend = 1;
            rd_exp  = sid_rdata;
          end else begin
            check("rd_valid_on_write", {31'd0, rd_valid}, 32'd0);
          end
        end
        free_c = cyc + 1;
      end
      if (cmd_valid && cmd_ready) begin
        q.push_back('{d: int'(cmd_delay), sel: cmd_sel, a: cmd_addr, dt: cmd_data, pc: cyc});
        accepted++;
      end
      if (flush) begin
        q.delete();
        free_c = cyc + 1;
      end
    end
    cyc++;
  end

  task automatic push(input int d, input bit s, input logic [4:0] a, input logic [7:0] dt);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_delay = 16'(d);
    cmd_sel   = s;
    cmd_addr  = a;
    cmd_data  = dt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (sid_cs == 2'b00 && !sid_we && i < budget);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  int n_ce;
  int acc0;
  int str0;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_delay = '0; cmd_sel = 1'b0;
    cmd_addr = '0; cmd_data = '0; flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", {30'd0, sid_cs}, 32'd0);
    check("rst_we", {31'd0, sid_we}, 32'd0);
    check("rst_addr", {27'd0, sid_addr}, 32'd0);
    check("rst_data", {24'd0, sid_data}, 32'd0);
    check("rst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Single write, ce every 32 clk
    push(0, 1'b0, 5'h18, 8'h0F);
    wait_strobe(200);
    check("t1_cs", {30'd0, sid_cs}, 32'd1);
    check("t1_we", {31'd0, sid_we}, 32'd1);
    check("t1_addr", {27'd0, sid_addr}, 32'h18);
    check("t1_data", {24'd0, sid_data}, 32'h0F);
    @(negedge clk);
    check("t1_we_drop", {29'd0, sid_we, sid_cs}, 32'd0);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);

    // Delay 3 with pause held across 2 ticks: strobe after the 6th tick
    push(3, 1'b1, 5'h04, 8'h41);
    @(posedge clk); #1 pause_force = 1;
    n_ce = 0;
    for (int i = 0; i < 200 && n_ce < 2; i++) begin
      @(negedge clk);
      if (ce_1m) n_ce++;
    end
    @(posedge clk); #1 pause_force = 0;
    for (int i = 0; i < 400 && sid_cs == 2'b00; i++) begin
      @(negedge clk);
      if (sid_cs == 2'b00 && ce_1m) n_ce++;
    end
    check("t2_ticks", n_ce, 32'd6);
    check("t2_cs", {30'd0, sid_cs}, 32'd2);
    check("t2_addr_data", {19'd0, sid_addr, sid_data}, {19'd0, 5'h04, 8'h41});

    // Full FIFO: 20 offers, 17 accepted
    ce_per = 4;
    acc0 = accepted;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_delay = 16'd100; cmd_sel = i[0];
      cmd_addr = 5'(i); cmd_data = 8'(8'h80 + i);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("t3_accepted", accepted - acc0, 32'd17);
    check("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
    check("t3_level_full", {27'd0, fifo_level}, 32'd16);
    wait_strobe(600);
    @(negedge clk); @(negedge clk);
    check("t3_level_after_pop", {27'd0, fifo_level}, 32'd15);
    check("t3_ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    wait_strobe(600);
    wait_strobe(600);
    pulse_flush();
    @(negedge clk);
    check("t3_flush_level", {27'd0, fifo_level}, 32'd0);

    // Flush during WAIT with 5 queued, push offered during flush
    for (int i = 0; i < 6; i++) push(50, 1'b0, 5'(i + 3), 8'(i));
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; cmd_valid = 1'b1; cmd_delay = 16'd0; cmd_addr = 5'h07; cmd_data = 8'hEE;
    @(negedge clk);
    check("t4_ready_in_flush", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1 flush = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_level", {27'd0, fifo_level}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    str0 = strobes;
    repeat (400) @(negedge clk);
    #1 check("t4_no_strobe", strobes - str0, 32'd0);

    // Reset mid-WAIT
    push(20, 1'b1, 5'h0A, 8'h55);
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t5_outs_zero", {15'd0, sid_cs, sid_we, sid_addr, sid_data}, 32'd0);
    check("t5_level_busy", {26'd0, fifo_level, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    str0 = strobes;
    repeat (200) @(negedge clk);
    #1 check("t5_no_strobe", strobes - str0, 32'd0);
    check("t5_level", {27'd0, fifo_level}, 32'd0);

`ifdef SID_SEQ_READBACK_EN
    // Readback of register 0x1B
    rdata_fix = 8'hA5;
    push(0, 1'b1, 5'h1B, 8'h33);
    wait_strobe(100);
    check("t6_we", {31'd0, sid_we}, 32'd0);
    check("t6_cs", {30'd0, sid_cs}, 32'd2);
    @(negedge clk);
    check("t6_cs_drop", {30'd0, sid_cs}, 32'd0);
    check("t6_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("t6_rd_data", {24'd0, rd_data}, 32'hA5);
    @(negedge clk);
    check("t6_rd_valid_drop", {31'd0, rd_valid}, 32'd0);
`endif

    // Randomized traffic against the scoreboard
    ce_per = 5;
    pause_rand = 1;
    rdata_rand = 1;
    acc0 = accepted;
    str0 = strobes;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      push(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), 8'($urandom));
    end
    for (int i = 0; i < 5000 && (busy || q.size() != 0); i++) @(negedge clk);
    #1;
    check("rand_busy", {31'd0, busy}, 32'd0);
    check("rand_level", {27'd0, fifo_level}, 32'd0);
    check("rand_count", strobes - str0, accepted - acc0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
